// File: rtl/lbp_stream_feeder.sv
// Channel-multiplexed sample stream to per-channel LBP code frames.
// Define LBP_FEEDER_DROP_EN to drop frames instead of backpressuring.
module lbp_stream_feeder #(
    parameter int E          = 64,
    parameter int LBP_LENGTH = 6,
    parameter int SAMPLE_W   = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_n_in,
    input  logic [SAMPLE_W-1:0]     sample_i,
    input  logic                    sample_valid_i,
    output logic                    sample_ready_o,
    output logic [E*LBP_LENGTH-1:0] LBP_codes_o,
    output logic                    frame_valid_o,
    input  logic                    send_next_LBP,
    output logic [15:0]             overrun_cnt_o
);

    localparam int CW = (E > 1) ? $clog2(E) : 1;
    localparam int WW = $clog2(LBP_LENGTH + 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(E - 1);
    localparam logic [WW-1:0] WARM_LAST = WW'(LBP_LENGTH);

    typedef enum logic {
        WARMUP,
        RUN
    } state_t;

    state_t                     state;
    logic [CW-1:0]              chan_cnt;
    logic [WW-1:0]              warm_cnt;
    logic signed [SAMPLE_W-1:0] prev [E];
    logic [LBP_LENGTH-1:0]      code [E];

    logic                    accept;
    logic                    last_ch;
    logic                    frame_done;
    logic                    new_bit;
    logic                    pub_ok;
    logic                    publish;
    logic                    consume;
    logic [LBP_LENGTH-1:0]   code_upd;
    logic [E*LBP_LENGTH-1:0] codes_next;

    assign last_ch    = (chan_cnt == LAST_CH);
    assign accept     = sample_valid_i && sample_ready_o;
    assign frame_done = accept && last_ch;
    assign new_bit    = $signed(sample_i) > prev[chan_cnt];
    assign code_upd   = {code[chan_cnt][LBP_LENGTH-2:0], new_bit};
    assign consume    = frame_valid_o && send_next_LBP;
    assign pub_ok     = (state == RUN) || (warm_cnt == WARM_LAST);

    // Last channel is published with the bit it is receiving right now
    always_comb begin
        codes_next = '0;
        for (int c = 0; c < E; c++) begin
            if (c == E - 1)
                codes_next[c*LBP_LENGTH +: LBP_LENGTH] = code_upd;
            else
                codes_next[c*LBP_LENGTH +: LBP_LENGTH] = code[c];
        end
    end

`ifdef LBP_FEEDER_DROP_EN
    logic drop;

    assign sample_ready_o = 1'b1;
    assign drop           = frame_done && pub_ok &&
                            frame_valid_o && !send_next_LBP;
    assign publish        = frame_done && pub_ok && !drop;

    always_ff @(posedge clk_i or negedge arst_n_in) begin
        if (!arst_n_in) begin
            overrun_cnt_o <= '0;
        end else if (drop && (overrun_cnt_o != 16'hFFFF)) begin
            overrun_cnt_o <= overrun_cnt_o + 16'd1;
        end
    end
`else
    assign sample_ready_o = (state != RUN) ||
                            !(last_ch && frame_valid_o && !send_next_LBP);
    assign publish        = frame_done && pub_ok;
    assign overrun_cnt_o  = '0;
`endif

    always_ff @(posedge clk_i or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state         <= WARMUP;
            chan_cnt      <= '0;
            warm_cnt      <= '0;
            LBP_codes_o   <= '0;
            frame_valid_o <= 1'b0;
            for (int c = 0; c < E; c++) begin
                prev[c] <= '0;
                code[c] <= '0;
            end
        end else begin
            // Frame-0 bits are garbage but get shifted out during warmup
            if (accept) begin
                prev[chan_cnt] <= $signed(sample_i);
                code[chan_cnt] <= code_upd;
                chan_cnt       <= last_ch ? '0 : chan_cnt + 1'b1;
            end
            if (frame_done && (state == WARMUP)) begin
                if (warm_cnt == WARM_LAST)
                    state <= RUN;
                else
                    warm_cnt <= warm_cnt + 1'b1;
            end
            if (publish) begin
                LBP_codes_o   <= codes_next;
                frame_valid_o <= 1'b1;
            end else if (consume) begin
                frame_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lbp_stream_feeder.sv
// Scoreboard bench for lbp_stream_feeder at E=4, LBP_LENGTH=6.
// Build with LBP_FEEDER_DROP_EN to exercise the frame-drop variant.
module tb_lbp_stream_feeder;

    localparam int E  = 4;
    localparam int L  = 6;
    localparam int W  = 16;
    localparam int CB = E * L;

    logic          clk_i = 1'b0;
    logic          arst_n_in = 1'b0;
    logic [W-1:0]  sample_i = '0;
    logic          sample_valid_i = 1'b0;
    logic          sample_ready_o;
    logic [CB-1:0] LBP_codes_o;
    logic          frame_valid_o;
    logic          send_next_LBP = 1'b0;
    logic [15:0]   overrun_cnt_o;

    lbp_stream_feeder #(.E(E), .LBP_LENGTH(L), .SAMPLE_W(W)) dut (
        .clk_i          (clk_i),
        .arst_n_in      (arst_n_in),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .LBP_codes_o    (LBP_codes_o),
        .frame_valid_o  (frame_valid_o),
        .send_next_LBP  (send_next_LBP),
        .overrun_cnt_o  (overrun_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    logic signed [W-1:0] m_prev [E];
    logic [L-1:0]        m_code [E];
    int                  m_warm;
    bit                  m_run;
    bit                  m_valid;
    logic [CB-1:0]       m_pub;
    logic [CB-1:0]       q [$];
    int                  tb_ch;
    logic                drv_last = 1'b0;

    task automatic model_reset();
        for (int c = 0; c < E; c++) begin
            m_prev[c] = '0;
            m_code[c] = '0;
        end
        m_warm  = 0;
        m_run   = 0;
        m_valid = 0;
        m_pub   = '0;
        tb_ch   = 0;
        q.delete();
    endtask

    task automatic model_accept(input logic [W-1:0] s);
        logic          b;
        logic          pub;
        logic [CB-1:0] v;
        b = ($signed(s) > m_prev[tb_ch]);
        m_code[tb_ch] = {m_code[tb_ch][L-2:0], b};
        m_prev[tb_ch] = $signed(s);
        if (tb_ch == E - 1) begin
            if (m_run || m_warm == L) begin
                m_run = 1;
`ifdef LBP_FEEDER_DROP_EN
                pub = send_next_LBP || !m_valid;
`else
                pub = 1'b1;
`endif
                for (int c = 0; c < E; c++) v[c*L +: L] = m_code[c];
                if (pub) begin
                    m_pub   = v;
                    m_valid = 1;
                end
                q.push_back(m_pub);
            end else begin
                m_warm++;
            end
        end
        tb_ch = (tb_ch + 1) % E;
    endtask

    task automatic drive(input logic [W-1:0] s);
        int n;
        @(negedge clk_i);
        sample_i       = s;
        sample_valid_i = 1'b1;
        drv_last       = (tb_ch == E - 1);
        model_accept(s);
        #1;
        n = 0;
        while (!sample_ready_o && n < 200) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        if (n == 200) check("ready_timeout", 0, 1);
`ifdef LBP_FEEDER_DROP_EN
        check("drop_ready_hi", {31'd0, sample_ready_o}, 1);
`endif
        @(posedge clk_i);
    endtask

    task automatic drive_frame(input logic [W-1:0] s);
        for (int c = 0; c < E; c++) drive(s);
    endtask

    task automatic idle();
        @(negedge clk_i);
        sample_valid_i = 1'b0;
        drv_last       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        sample_valid_i = 1'b0;
        drv_last       = 1'b0;
        arst_n_in      = 1'b0;
        model_reset();
        @(negedge clk_i);
        arst_n_in = 1'b1;
    endtask

    logic          mon_pe;
    logic [CB-1:0] mon_exp;

    always begin
        @(posedge clk_i);
        mon_pe = arst_n_in && sample_valid_i && sample_ready_o && drv_last;
        #1;
        if (mon_pe && q.size() > 0) begin
            mon_exp = q.pop_front();
            check("frame_codes", {8'd0, LBP_codes_o}, {8'd0, mon_exp});
            check("frame_valid", {31'd0, frame_valid_o}, 1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk_i);
        check("rst_codes", {8'd0, LBP_codes_o}, 0);
        check("rst_valid", {31'd0, frame_valid_o}, 0);
        check("rst_ready", {31'd0, sample_ready_o}, 1);
        check("rst_overrun", {16'd0, overrun_cnt_o}, 0);
        @(negedge clk_i);
        arst_n_in = 1'b1;

        send_next_LBP = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < E; c++) begin
                if (k == 6 && c == 3) begin
                    #1;
                    check("ramp_pre_valid", {31'd0, frame_valid_o}, 0);
                end
                drive(16'(k));
            end
        end
        idle();
        check("ramp63", {8'd0, LBP_codes_o}, 32'h00FF_FFFF);

        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive_frame((k % 2) ? 16'd10 : 16'd0);
            #1;
            if (k == 6) check("alt42", {8'd0, LBP_codes_o}, 32'h00AA_AAAA);
            if (k == 7) check("alt21", {8'd0, LBP_codes_o}, 32'h0055_5555);
        end
        idle();

        do_reset();
        for (int k = 0; k < 7; k++) begin
            drive((k % 2) ? 16'h0001 : 16'hFFFF);
            drive(16'd5);
            drive((k % 2) ? 16'h7FFF : 16'h8000);
            drive(16'(-k));
        end
        idle();
        check("signed_flat", {8'd0, LBP_codes_o}, 32'h0002_A02A);

`ifndef LBP_FEEDER_DROP_EN
        do_reset();
        send_next_LBP = 1'b0;
        @(negedge clk_i);
        send_next_LBP = 1'b1;
        @(negedge clk_i);
        send_next_LBP = 1'b0;
        for (int k = 0; k < 7; k++) drive_frame(16'(k));
        idle();
        repeat (2) @(negedge clk_i);
        check("bp_hold_valid", {31'd0, frame_valid_o}, 1);
        for (int c = 0; c < 3; c++) drive(16'd0);
        @(negedge clk_i);
        sample_i       = 16'd0;
        sample_valid_i = 1'b1;
        drv_last       = 1'b1;
        model_accept(16'd0);
        #1;
        check("bp_ready_lo", {31'd0, sample_ready_o}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            check("bp_stall_ready", {31'd0, sample_ready_o}, 0);
            check("bp_stall_codes", {8'd0, LBP_codes_o}, 32'h00FF_FFFF);
        end
        @(negedge clk_i);
        send_next_LBP = 1'b1;
        #1;
        check("bp_pulse_ready", {31'd0, sample_ready_o}, 1);
        @(posedge clk_i);
        @(negedge clk_i);
        send_next_LBP  = 1'b0;
        sample_valid_i = 1'b0;
        drv_last       = 1'b0;
        #1;
        check("bp_valid_kept", {31'd0, frame_valid_o}, 1);
        check("bp_new_codes", {8'd0, LBP_codes_o}, 32'h00FB_EFBE);
`endif

        do_reset();
        send_next_LBP = 1'b1;
        for (int k = 0; k < 9; k++) drive_frame(16'(k));
        drive(16'd9);
        drive(16'd9);
        @(negedge clk_i);
        sample_valid_i = 1'b0;
        drv_last       = 1'b0;
        arst_n_in      = 1'b0;
        #1;
        check("mid_rst_codes", {8'd0, LBP_codes_o}, 0);
        check("mid_rst_valid", {31'd0, frame_valid_o}, 0);
        check("mid_rst_ready", {31'd0, sample_ready_o}, 1);
        check("mid_rst_overrun", {16'd0, overrun_cnt_o}, 0);
        model_reset();
        @(negedge clk_i);
        arst_n_in = 1'b1;
        for (int k = 0; k < 6; k++) drive_frame(16'(100 + k));
        for (int c = 0; c < 3; c++) drive(16'd106);
        #1;
        check("mid_rst_pre_valid", {31'd0, frame_valid_o}, 0);
        drive(16'd106);
        idle();

`ifdef LBP_FEEDER_DROP_EN
        do_reset();
        send_next_LBP = 1'b0;
        for (int k = 0; k < 9; k++) drive_frame(16'(k));
        idle();
        #1;
        check("drop_overrun", {16'd0, overrun_cnt_o}, 2);
        check("drop_retained", {8'd0, LBP_codes_o}, 32'h00FF_FFFF);
        check("drop_valid", {31'd0, frame_valid_o}, 1);
`else
        check("overrun_tied0", {16'd0, overrun_cnt_o}, 0);
`endif

        repeat (2) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
